// File: rtl/seq_det_ctrl.sv
// Streaming programmable Moore sequence detector controller.
// Bytes arrive over valid/ready, are serialised MSB-first into a bit history and
// compared against a programmable pattern; matches are counted with a sticky
// threshold flag.
// Optional build macro: SEQ_DET_NONOVERLAP_EN selects non-overlapping detection
// (history is cleared on every match).
module seq_det_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               thresh_hit
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned FillW   = $clog2(PAT_MAX + 1);

  localparam logic [PAT_MAX-1:0] DefPattern = PAT_MAX'(5'b10110);
  localparam logic [3:0]         DefLen     = 4'd5;
  localparam logic [CNT_W-1:0]   DefThresh  = CNT_W'(1);
  localparam logic [3:0]         PatMaxLen  = 4'(PAT_MAX);
  localparam logic [FillW-1:0]   FillMax    = FillW'(PAT_MAX);
  localparam logic [CNT_W-1:0]   CntMax     = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]  word_q, word_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               thresh_hit_q, thresh_hit_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;

  logic               len_valid;
  logic               accept;
  logic               shift_en;
  logic               last_bit;
  logic [PAT_MAX-1:0] len_mask;
  logic [PAT_MAX-1:0] hist_nxt;
  logic [FillW-1:0]   fill_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pat_found;

  assign len_valid = (len_q != 4'd0) && (len_q <= PatMaxLen);
  assign last_bit  = (bit_cnt_q == '0);
  assign accept    = in_valid & in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a word accepted on the last bit keeps the FSM in StShift
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (last_bit && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q == StShift);
    shift_en = (state_q == StShift);
    in_ready = len_valid & ((state_q == StIdle) | ((state_q == StShift) & last_bit));
  end

  // Bit-history compare for the bit shifted at this edge
  always_comb begin
    for (int i = 0; i < int'(PAT_MAX); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hist_nxt  = {hist_q[PAT_MAX-2:0], word_q[bit_cnt_q]};
    fill_nxt  = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    pat_found = (int'(fill_nxt) >= int'(len_q)) && (((hist_nxt ^ pat_q) & len_mask) == '0);
  end

  // Datapath next state; priority clr > cfg_we > shifting
  always_comb begin
    word_d       = word_q;
    bit_cnt_d    = bit_cnt_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    match_d      = 1'b0;
    cnt_d        = cnt_q;
    thresh_hit_d = thresh_hit_q;
    pat_d        = pat_q;
    len_d        = len_q;
    thresh_d     = thresh_q;

    // Serialiser runs regardless of clr so an in-flight word keeps shifting
    if (accept) begin
      word_d    = in_data;
      bit_cnt_d = BitCntW'(DATA_W - 1);
    end else if (shift_en && !last_bit) begin
      bit_cnt_d = bit_cnt_q - BitCntW'(1);
    end

    if (clr) begin
      hist_d       = '0;
      fill_d       = '0;
      cnt_d        = '0;
      thresh_hit_d = 1'b0;
    end else if (cfg_we && (state_q == StIdle) && !accept) begin
      pat_d        = cfg_pattern;
      len_d        = cfg_len;
      thresh_d     = cfg_thresh;
      hist_d       = '0;
      fill_d       = '0;
      cnt_d        = '0;
      thresh_hit_d = 1'b0;
    end else if (shift_en) begin
      hist_d = hist_nxt;
      fill_d = fill_nxt;
      if (pat_found) begin
        match_d = 1'b1;
        cnt_d   = cnt_inc;
        if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
          thresh_hit_d = 1'b1;
        end
`ifdef SEQ_DET_NONOVERLAP_EN
        hist_d = '0;
        fill_d = '0;
`endif
      end
    end
  end

  // Datapath and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q       <= '0;
      bit_cnt_q    <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      match_q      <= 1'b0;
      cnt_q        <= '0;
      thresh_hit_q <= 1'b0;
      pat_q        <= DefPattern;
      len_q        <= DefLen;
      thresh_q     <= DefThresh;
    end else begin
      word_q       <= word_d;
      bit_cnt_q    <= bit_cnt_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      match_q      <= match_d;
      cnt_q        <= cnt_d;
      thresh_hit_q <= thresh_hit_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      thresh_q     <= thresh_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign thresh_hit  = thresh_hit_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-queue reference model predicts each
// match pulse (edge, count, flag); a negedge monitor pops and compares them.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_thresh = '0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       busy;
  logic       match;
  logic [7:0] match_count;
  logic       thresh_hit;

  seq_det_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_thresh (cfg_thresh),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .match      (match),
    .match_count(match_count),
    .thresh_hit (thresh_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       hit;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  bit         pend[$];   // bits still to be shifted, in order
  bit         hist[$];   // most recent bits, newest at the back
  logic [7:0] m_pat;
  int         m_len;
  logic [7:0] m_th;
  int         m_cnt;
  bit         m_hit;
  bit         chk_en = 0;
  bit         last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_len_ok();
    return (m_len >= 1) && (m_len <= 8);
  endfunction

  function automatic bit m_matches();
    if (!m_len_ok() || hist.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++) begin
      if (hist[hist.size() - 1 - i] != m_pat[i]) return 0;
    end
    return 1;
  endfunction

  // One clock cycle: drive inputs, check pre-edge state, advance model to the edge
  task automatic step(input bit v, input logic [7:0] d, input bit c, input bit we,
                      input logic [7:0] p, input logic [3:0] l, input logic [7:0] th,
                      input bit r);
    bit exp_ready;
    bit acc;
    bit have;
    bit b;
    int e;
    @(negedge clk);
    in_valid = v; in_data = d; clr = c; cfg_we = we;
    cfg_pattern = p; cfg_len = l; cfg_thresh = th; rst = r;
    #1;
    exp_ready = m_len_ok() && (pend.size() <= 1);
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(pend.size() != 0));
      chk("match_count", 32'(match_count), 32'(m_cnt));
      chk("thresh_hit", 32'(thresh_hit), 32'(m_hit));
    end
    e = cyc + 1;
    last_acc = 0;
    if (r) begin
      pend.delete(); hist.delete();
      m_cnt = 0; m_hit = 0; m_pat = 8'h16; m_len = 5; m_th = 8'd1;
    end else begin
      acc = v && exp_ready;
      last_acc = acc;
      have = (pend.size() > 0);
      b = 0;
      if (have) b = pend.pop_front();
      if (c) begin
        hist.delete(); m_cnt = 0; m_hit = 0;
      end else if (we && !have && !acc) begin
        m_pat = p; m_len = int'(l); m_th = th;
        hist.delete(); m_cnt = 0; m_hit = 0;
      end else if (have) begin
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
        if (m_matches()) begin
          if (m_cnt < 255) m_cnt++;
          if (m_th != 0 && m_cnt == int'(m_th)) m_hit = 1;
          sbq.push_back('{cyc: e, cnt: 8'(m_cnt), hit: m_hit});
`ifdef SEQ_DET_NONOVERLAP_EN
          hist.delete();
`endif
        end
      end
      if (acc) for (int k = 7; k >= 0; k--) pend.push_back(d[k]);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00, 0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] th);
    step(0, 8'h00, 0, 1, p, l, th, 0);
  endtask

  // Hold in_valid with the word until the model says it was taken
  task automatic send(input logic [7:0] d);
    int n = 0;
    do begin
      step(1, d, 0, 0, 8'h00, 4'd0, 8'h00, 0);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL send timeout: word %0h not accepted within 20 cycles", d);
    end
  endtask

  // Monitor: pop an expectation for every match pulse, flag missed pulses
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missed_match: expected pulse after edge %0d did not occur", sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (match === 1'b1) begin
      if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL spurious_match: pulse after edge %0d, expected none", cyc);
      end else begin
        chk("match_pulse_count", 32'(match_count), 32'(sbq[0].cnt));
        chk("match_pulse_thresh", 32'(thresh_hit), 32'(sbq[0].hit));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    step(0, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00, 1);
    chk_en = 1;
    step(0, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00, 1);
    idle(2);
    chk("reset_match", 32'(match), 32'd0);

    // Default pattern 10110 on 0xB6
    send(8'hB6);
    idle(10);

    // Cross-word match, back-to-back
    cfg(8'h16, 4'd5, 8'd1);
    send(8'h05);
    send(8'h80);
    idle(10);

    // Threshold 3 over two words
    cfg(8'h16, 4'd5, 8'd3);
    send(8'hB6);
    send(8'hB6);
    idle(10);

    // Short pattern 101
    cfg(8'h05, 4'd3, 8'd2);
    send(8'hAA);
    idle(10);

    // Invalid length blocks input
    cfg(8'h05, 4'd0, 8'd1);
    for (int i = 0; i < 4; i++) step(1, 8'hAA, 0, 0, 8'h00, 4'd0, 8'h00, 0);
    cfg(8'h05, 4'd9, 8'd1);
    for (int i = 0; i < 3; i++) step(1, 8'hAA, 0, 0, 8'h00, 4'd0, 8'h00, 0);

    // cfg_we while busy is ignored
    cfg(8'h16, 4'd5, 8'd1);
    send(8'hB6);
    step(0, 8'h00, 0, 1, 8'h03, 4'd2, 8'd5, 0);
    step(0, 8'h00, 0, 1, 8'h03, 4'd2, 8'd5, 0);
    idle(10);

    // clr on the completing edge of the first match
    send(8'hB6);
    idle(4);
    step(0, 8'h00, 1, 0, 8'h00, 4'd0, 8'h00, 0);
    idle(8);

    // Reset mid-word restores defaults
    cfg(8'h05, 4'd3, 8'd7);
    send(8'hAA);
    idle(3);
    step(0, 8'h00, 0, 0, 8'h00, 4'd0, 8'h00, 1);
    idle(2);
    send(8'hB6);
    idle(10);

    // Counter saturation
    cfg(8'h01, 4'd1, 8'd0);
    for (int i = 0; i < 33; i++) send(8'hFF);
    idle(10);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, c, we, r;
      logic [7:0] d, p, th;
      logic [3:0] l;
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      c  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 79) == 0);
      p  = 8'($urandom);
      l  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15) % 16) : 4'($urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) l = 4'd0;
      th = 8'($urandom_range(0, 6));
      r  = ($urandom_range(0, 599) == 0);
      step(v, d, c, we, p, l, th, r);
    end
    idle(12);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected pulses left, required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
